led_matrix_scan: RTL
====================

LED_MATRIX_SCAN -- requirements
Module: led_matrix_scan

Interface
REQ-001 SHALL have parameter ROWS, default 9, number of matrix rows (>=2).
REQ-002 SHALL have parameter COLS, default 8, number of matrix columns (>=1).
REQ-003 SHALL have parameter PERIOD, default 27000, sys_clk cycles per row slot.
REQ-004 SHALL have parameter GAP, default 500, blanking cycles at each end of a row slot; 1 <= GAP and 2*GAP < PERIOD.
REQ-005 SHALL have parameter BRIGHT_W, default 4, width of the brightness control.
REQ-006 SHALL have port sys_clk, input, 1 bit, the single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-008 SHALL have port wr_en, input, 1 bit, frame-buffer write strobe.
REQ-009 SHALL have port wr_row, input, $clog2(ROWS) bits, row index to write.
REQ-010 SHALL have port wr_data, input, COLS bits, column pattern for wr_row (1 = LED on).
REQ-011 SHALL have port bright, input, BRIGHT_W bits, global brightness (0 = dark, all-ones = full).
REQ-012 SHALL have port led_col, output, COLS bits, column drive.
REQ-013 SHALL have port led_row, output, ROWS bits, one-hot row drive.
REQ-014 SHALL have port frame_start, output, 1 bit, one-cycle pulse at start of row 0.

Function
REQ-015 SHALL hold a ROWS x COLS frame buffer; wr_en=1 with wr_row<ROWS writes wr_data at the clock edge; wr_row>=ROWS is ignored.
REQ-016 SHALL run counter 0..PERIOD-1, wrapping PERIOD-1 -> 0.
REQ-017 SHALL advance row_index at the edge where counter==PERIOD-1, wrapping ROWS-1 -> 0 (no power-of-two wrap).
REQ-018 SHALL, at the edge ending a cycle with counter==0, latch pat_l = frame_buf[row_index] (pre-write value if same-cycle write to that row) and bright_l = bright.
REQ-019 SHALL compute ACTIVE = PERIOD-2*GAP and lit_len = ACTIVE if bright_l is all-ones, else (ACTIVE*bright_l)>>BRIGHT_W; no truncation in the product.
REQ-020 SHALL define lit(c) = (GAP <= c) and (c < GAP+lit_len).
REQ-021 SHALL register outputs: at the edge ending a cycle with counter==c, led_row <= lit(c) ? (1<<row_index) : 0, and led_col <= lit(c) ? pat_l : 0.
REQ-022 SHALL never assert more than one led_row bit, and SHALL drive led_row=0 for at least 2*GAP consecutive cycles around each row change.
REQ-023 SHALL drive frame_start combinationally = (counter==0 and row_index==0).
REQ-024 SHALL leave bright changes mid-slot without effect until the next row latch.
REQ-025 SHALL keep writes during a row's slot from affecting that slot; they take effect at that row's next latch.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, clear counter, row_index, frame buffer, pat_l, bright_l, led_row, and led_col to 0.
REQ-027 SHALL resume after rst deasserts with counter=0 and row_index=0, so frame_start is high in the first cycle after reset.
REQ-028 SHALL make mid-slot reset blank outputs on the same edge and discard the partial slot.

Verification (ROWS=3, COLS=4, PERIOD=20, GAP=2, BRIGHT_W=2; ACTIVE=16)
REQ-029 SHALL verify reset: rst high 3 cycles, then release -> led_row=0, led_col=0, frame_start=1 in first post-reset cycle, then again every 60 cycles.
REQ-030 SHALL verify full brightness: write row1=4'b1010, bright=3 -> in row1 slot, led_row=3'b010 and led_col=4'b1010 for exactly 16 cycles (counter 2..17, outputs one cycle later), 0 otherwise.
REQ-031 SHALL verify partial and zero brightness: bright=1 -> lit 4 cycles per slot; bright=0 -> led_row stays 0 for a whole frame.
REQ-032 SHALL verify write/latch collision: write row0=4'b1111 in the counter==0, row_index==0 cycle while old value is 4'b0001 -> this slot shows 4'b0001, next frame shows 4'b1111.
REQ-033 SHALL verify out-of-range and wrap behaviour: wr_row=3 leaves all rows unchanged, and row_index sequence is 0,1,2,0 with a one-hot led_row.
REQ-034 SHALL verify mid-slot reset: rst at counter=10 of row 2 -> outputs 0 next edge, and the restart is at row 0, counter 0, with an empty buffer.

Source files
------------

// File: rtl/led_matrix_scan_if.sv
// led_matrix_scan_if: frame-buffer write port, brightness control and LED drive outputs
interface led_matrix_scan_if #(
  parameter int ROWS = 9,
  parameter int COLS = 8,
  parameter int BRIGHT_W = 4
) ();
  logic                    wr_en;
  logic [$clog2(ROWS)-1:0] wr_row;
  logic [COLS-1:0]         wr_data;
  logic [BRIGHT_W-1:0]     bright;
  logic [COLS-1:0]         led_col;
  logic [ROWS-1:0]         led_row;
  logic                    frame_start;
  modport master (output wr_en, wr_row, wr_data, bright, input led_col, led_row, frame_start);
  modport slave  (input wr_en, wr_row, wr_data, bright, output led_col, led_row, frame_start);
endinterface

// File: rtl/led_matrix_scan.sv
// led_matrix_scan: row-multiplexed LED matrix driver with frame buffer and PWM-style brightness
module led_matrix_scan #(
  parameter int ROWS = 9,
  parameter int COLS = 8,
  parameter int PERIOD = 27000,
  parameter int GAP = 500,
  parameter int BRIGHT_W = 4
) (
  input logic               sys_clk,
  input logic               rst,
  led_matrix_scan_if.slave  bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(PERIOD);
  localparam int ACTIVE = PERIOD - 2 * GAP;
  logic [CW-1:0]       counter;
  logic [RW-1:0]       row_index;
  logic [COLS-1:0]     frame_buf [ROWS];
  logic [COLS-1:0]     pat_l;
  logic [BRIGHT_W-1:0] bright_l;
  logic [ROWS-1:0]     led_row_q;
  logic [COLS-1:0]     led_col_q;
  logic [63:0]         lit_len;
  logic                lit;
  // full brightness bypasses the scaling so all-ones means the whole active window
  always_comb begin
    lit_len = &bright_l ? 64'(ACTIVE) : (64'(ACTIVE) * 64'(bright_l)) >> BRIGHT_W;
    lit = 64'(counter) >= 64'(GAP) && 64'(counter) < 64'(GAP) + lit_len;
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      counter <= '0;
      row_index <= '0;
      for (int i = 0; i < ROWS; i++) frame_buf[i] <= '0;
      pat_l <= '0;
      bright_l <= '0;
      led_row_q <= '0;
      led_col_q <= '0;
    end else begin
      counter <= counter == CW'(PERIOD - 1) ? '0 : counter + 1'b1;
      if (counter == CW'(PERIOD - 1))
        row_index <= row_index == RW'(ROWS - 1) ? '0 : row_index + 1'b1;
      if (counter == '0) begin
        pat_l <= frame_buf[row_index];
        bright_l <= bus.bright;
      end
      if (bus.wr_en && 32'(bus.wr_row) < ROWS)
        frame_buf[bus.wr_row] <= bus.wr_data;
      led_row_q <= lit ? ROWS'(1) << row_index : '0;
      led_col_q <= lit ? pat_l : '0;
    end
  end
  assign bus.led_row = led_row_q;
  assign bus.led_col = led_col_q;
  assign bus.frame_start = counter == '0 && row_index == '0;
endmodule
